// File: rtl/uart_tx_fifo.sv
// UART transmit holding FIFO with THR-empty interrupt state and level/status flags.
// Optional sticky overflow flag is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   fifo_en,
  input  logic                   tx_clr,
  input  logic                   ier_thre,
  input  logic                   iir_rd,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   thre,
  output logic [3:0]             iir,
  output logic                   ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_THRE = 4'b0010;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              clr;
  logic              full_s;
  logic              empty_s;
  logic              wr_acc;
  logic              rd_acc;
  logic              thre_int;
  logic              thre_int_nxt;
  logic              ier_q;

  // Accept decisions; a clear (or disabled FIFO) overrides both strobes.
  always_comb begin
    clr     = tx_clr | ~fifo_en;
    full_s  = (count == CW'(DEPTH));
    empty_s = (count == '0);
    rd_acc  = rd_en & ~clr & ~empty_s;
    wr_acc  = wr_en & ~clr & (~full_s | rd_acc);
  end

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Storage array carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Head is sampled before a same-edge write can overwrite it when full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
    end
  end

  // THRE interrupt: host ack clears, empty events set, an accepted write wins.
  always_comb begin
    thre_int_nxt = thre_int;
    if (iir_rd && ier_thre && thre_int) begin
      thre_int_nxt = 1'b0;
    end
    if (ier_thre && ((!empty_s && count_nxt == '0) || (!ier_q && empty_s))) begin
      thre_int_nxt = 1'b1;
    end
    if (wr_acc) begin
      thre_int_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thre_int <= 1'b0;
      ier_q    <= 1'b0;
    end else begin
      thre_int <= thre_int_nxt;
      ier_q    <= ier_thre;
    end
  end

  assign level = count;
  assign full  = full_s;
  assign empty = empty_s;
  assign thre  = empty_s;
  assign iir   = (ier_thre && thre_int) ? IIR_THRE : IIR_NONE;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_set;

  assign ovf_set = wr_en & ~clr & full_s & ~rd_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (tx_clr || iir_rd) begin
      ovf <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          fifo_en = 1'b1;
  logic          tx_clr = 1'b0;
  logic          ier_thre = 1'b0;
  logic          iir_rd = 1'b0;
  logic [5:0]    level;
  logic          full;
  logic          empty;
  logic          thre;
  logic [3:0]    iir;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq [$];
  logic          m_int;
  logic          m_ovf;
  logic          m_ier_q;
  logic          m_rv;
  logic [DW-1:0] m_rd;

  uart_tx_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_en(fifo_en), .tx_clr(tx_clr),
    .ier_thre(ier_thre), .iir_rd(iir_rd), .level(level), .full(full), .empty(empty),
    .thre(thre), .iir(iir), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_int = 1'b0; m_ovf = 1'b0; m_ier_q = 1'b0; m_rv = 1'b0; m_rd = '0;
  endtask

  // Advance one clock and update the model from the inputs present at that edge.
  task automatic tick();
    bit clr, rd_ok, wr_ok, pend;
    int n0;
    n0    = mq.size();
    clr   = tx_clr || !fifo_en;
    rd_ok = !clr && rd_en && n0 > 0;
    wr_ok = !clr && wr_en && (n0 < DEPTH || rd_ok);
    pend  = ier_thre && m_int;
    if (OVF_ON) begin
      if (wr_en && !clr && n0 == DEPTH && !rd_ok) m_ovf = 1'b1;
      else if (tx_clr || iir_rd) m_ovf = 1'b0;
    end
    if (clr) begin
      mq.delete();
      m_rv = 1'b0;
    end else begin
      m_rv = rd_ok;
      if (rd_ok) m_rd = mq.pop_front();
      if (wr_ok) mq.push_back(wr_data);
    end
    if (iir_rd && pend) m_int = 1'b0;
    if (ier_thre && ((n0 != 0 && mq.size() == 0) || (!m_ier_q && n0 == 0))) m_int = 1'b1;
    if (wr_ok) m_int = 1'b0;
    m_ier_q = ier_thre;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_iir();
    return (ier_thre && m_int) ? 4'b0010 : 4'b0001;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #3;
    model_reset();
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || thre !== 1'b1) begin errors++; $display("FAIL reset_flags got e%b f%b t%b exp e1 f0 t1", empty, full, thre); end
    checks++; if (iir !== 4'b0001) begin errors++; $display("FAIL reset_iir got %b exp 0001", iir); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || ovf !== 1'b0) begin errors++; $display("FAIL reset_rd got v%b d%h o%b exp v0 d00 o0", rd_valid, rd_data, ovf); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] e;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h41 + i); tick();
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || level !== 6'd32) begin errors++; $display("FAIL fill_full got f%b l%0d exp f1 l32", full, level); end
    wr_en = 1'b1; wr_data = 8'hFF; tick(); wr_en = 1'b0;
    checks++; if (level !== 6'd32 || ovf !== OVF_ON) begin errors++; $display("FAIL drop_write got l%0d o%b exp l32 o%b", level, ovf, OVF_ON); end
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; tick();
      e = 8'(8'h41 + i);
      checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin errors++; $display("FAIL drain_%0d got v%b d%h exp v1 d%h", i, rd_valid, rd_data, e); end
    end
    rd_en = 1'b0; tick();
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h60) begin errors++; $display("FAIL drain_end got v%b e%b d%h exp v0 e1 d60", rd_valid, empty, rd_data); end
    checks++; if (ovf !== OVF_ON) begin errors++; $display("FAIL ovf_hold got %b exp %b", ovf, OVF_ON); end
    iir_rd = 1'b1; tick(); iir_rd = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_wrap();
    int n;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 20 : 30;
      for (int i = 0; i < n; i++) begin
        wr_en = 1'b1; wr_data = 8'($urandom); tick();
      end
      wr_en = 1'b0;
      checks++; if (level !== 6'(n)) begin errors++; $display("FAIL wrap_level got %0d exp %0d", level, n); end
      for (int i = 0; i < n; i++) begin
        rd_en = 1'b1; tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== m_rd) begin errors++; $display("FAIL wrap_rd_%0d_%0d got v%b d%h exp v1 d%h", r, i, rd_valid, rd_data, m_rd); end
      end
      rd_en = 1'b0;
    end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] head;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 200)); tick();
    end
    head = mq[0];
    rd_en = 1'b1; wr_data = 8'hAA; tick();
    wr_en = 1'b0;
    checks++; if (level !== 6'd32 || rd_valid !== 1'b1 || rd_data !== head) begin errors++; $display("FAIL full_rw got l%0d v%b d%h exp l32 v1 d%h", level, rd_valid, rd_data, head); end
    for (int i = 0; i < 32; i++) tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== 8'hAA || empty !== 1'b1) begin errors++; $display("FAIL full_rw_last got d%h e%b exp dAA e1", rd_data, empty); end
    tick();
  endtask

  task automatic test_thre_irq();
    ier_thre = 1'b1; tick();
    checks++; if (iir !== 4'b0010) begin errors++; $display("FAIL irq_rise got %b exp 0010", iir); end
    wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
    checks++; if (iir !== 4'b0001 || thre !== 1'b0) begin errors++; $display("FAIL irq_wr got %b t%b exp 0001 t0", iir, thre); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (iir !== 4'b0010 || rd_data !== 8'h55) begin errors++; $display("FAIL irq_empty got %b d%h exp 0010 d55", iir, rd_data); end
    iir_rd = 1'b1; tick(); iir_rd = 1'b0;
    checks++; if (iir !== 4'b0001) begin errors++; $display("FAIL irq_ack got %b exp 0001", iir); end
    wr_en = 1'b1; wr_data = 8'h66; tick(); wr_en = 1'b0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (iir !== 4'b0010) begin errors++; $display("FAIL irq_again got %b exp 0010", iir); end
    ier_thre = 1'b0; #1;
    checks++; if (iir !== 4'b0001) begin errors++; $display("FAIL irq_mask got %b exp 0001", iir); end
    ier_thre = 1'b1; #1;
    wr_en = 1'b1; wr_data = 8'h11; tick(); wr_en = 1'b0;
    checks++; if (iir !== 4'b0001) begin errors++; $display("FAIL irq_wrclr got %b exp 0001", iir); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    ier_thre = 1'b0; tick();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); tick();
    end
    checks++; if (level !== 6'd10) begin errors++; $display("FAIL clr_pre got %0d exp 10", level); end
    tx_clr = 1'b1; wr_data = 8'h99; tick();
    tx_clr = 1'b0; wr_en = 1'b0;
    checks++; if (level !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL clr_post got l%0d e%b v%b exp l0 e1 v0", level, empty, rd_valid); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL clr_rd_empty got %b exp 0", rd_valid); end
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); tick();
    end
    wr_en = 1'b0; fifo_en = 1'b0; tick(); fifo_en = 1'b1;
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL fifo_dis got %0d exp 0", level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); tick();
    end
    wr_en = 1'b0; rd_en = 1'b1; tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (level !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || thre !== 1'b1 || iir !== 4'b0001) begin errors++; $display("FAIL rstmid_flags got l%0d e%b f%b t%b i%b", level, empty, full, thre, iir); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_rd got v%b d%h exp v0 d00", rd_valid, rd_data); end
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (rd_valid !== 1'b0 || level !== 6'd0) begin errors++; $display("FAIL rstmid_after got v%b l%0d exp v0 l0", rd_valid, level); end
  endtask

  task automatic test_random();
    int wp;
    for (int c = 0; c < 600; c++) begin
      wp = ((c / 100) % 2 == 0) ? 80 : 30;
      wr_en    = ($urandom_range(0, 99) < wp);
      wr_data  = 8'($urandom);
      rd_en    = ($urandom_range(0, 99) < 55);
      fifo_en  = ($urandom_range(0, 79) != 0);
      tx_clr   = ($urandom_range(0, 99) == 0);
      iir_rd   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) ier_thre = ~ier_thre;
      tick();
      checks++; if (level !== 6'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || thre !== (mq.size() == 0))
        begin errors++; $display("FAIL rnd_level_%0d got l%0d f%b e%b t%b exp l%0d", c, level, full, empty, thre, mq.size()); end
      checks++; if (rd_valid !== m_rv || rd_data !== m_rd) begin errors++; $display("FAIL rnd_rd_%0d got v%b d%h exp v%b d%h", c, rd_valid, rd_data, m_rv, m_rd); end
      checks++; if (iir !== exp_iir() || ovf !== m_ovf) begin errors++; $display("FAIL rnd_irq_%0d got i%b o%b exp i%b o%b", c, iir, ovf, exp_iir(), m_ovf); end
    end
    wr_en = 1'b0; rd_en = 1'b0; tx_clr = 1'b0; iir_rd = 1'b0; fifo_en = 1'b1; ier_thre = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rw();
    test_thre_irq();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, character width in bits.
REQ-002 Parameter DEPTH, default 32, entries; power of two, 4..256; AW = log2(DEPTH).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  bus write strobe to THR.
REQ-006 wr_data  input  DATA_W  character to queue.
REQ-007 rd_en  input  1  transmitter load request (shift register free).
REQ-008 rd_data  output  DATA_W  character delivered to transmitter.
REQ-009 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-010 fifo_en  input  1  FCR[0], FIFO enable level.
REQ-011 tx_clr  input  1  FCR[2], clear pulse.
REQ-012 ier_thre  input  1  IER[1], THR-empty interrupt enable.
REQ-013 iir_rd  input  1  one-cycle strobe, host read IIR.
REQ-014 level  output  AW+1  current occupancy 0..DEPTH.
REQ-015 full / empty  output  1 each  level==DEPTH / level==0.
REQ-016 thre  output  1  LSR[5], equals empty.
REQ-017 iir  output  4  0001 no interrupt, 0010 THR empty pending.
REQ-018 ovf  output  1  sticky overflow flag (see Configuration).

Function
REQ-019 Storage shall be a circular buffer: wr_ptr, rd_ptr (AW bits, wrap DEPTH-1 -> 0), count (AW+1 bits); no data shifting.
REQ-020 Write accepted when wr_en=1, fifo_en=1, tx_clr=0, and not full (or full with simultaneous accepted read); writes on full without a read are dropped and stored data is unchanged.
REQ-021 Read accepted when rd_en=1, fifo_en=1, tx_clr=0, not empty; rd_data registered from head, rd_valid=1 the following cycle (latency 1).
REQ-022 rd_en while empty: no pointer change, rd_valid=0, rd_data holds last value.
REQ-023 Simultaneous accepted read and write: count unchanged, both pointers advance; when empty, only the write is accepted.
REQ-024 tx_clr=1 or fifo_en=0: pointers and count zeroed same edge, rd_valid=0, stored contents don't-care; tx_clr has priority over wr_en/rd_en.
REQ-025 THRE interrupt state: set on the edge where count becomes 0 (from read or clear) when ier_thre=1, or when ier_thre rises while empty.
REQ-026 THRE interrupt cleared by an accepted write or by iir_rd while iir==0010; ier_thre=0 forces iir=0001 combinationally.
REQ-027 level, full, empty, thre shall be registered-state derived, valid the cycle after the causing edge.

Reset
REQ-028 reset=0 asynchronously: pointers, count=0, rd_data=0, rd_valid=0, interrupt state=0, ovf=0.
REQ-029 Post-reset outputs: level=0, empty=1, full=0, thre=1, iir=0001.
REQ-030 Reset asserted mid-transfer aborts the transfer; no rd_valid after release without a new rd_en.

Configuration
REQ-031 Macro UART_TX_FIFO_OVF_EN defined: ovf set on a dropped write (REQ-020), held until reset, tx_clr, or iir_rd.
REQ-032 Macro undefined: ovf tied 0, no overflow logic synthesised; all other behaviour identical.

Verification
REQ-033 Reset, DEPTH=32: write 0x41..0x60 (32 writes) -> full=1, level=32; 33rd write 0xFF dropped; 32 reads return 0x41..0x60 in order, rd_valid one cycle after each rd_en.
REQ-034 Wrap: write 20, read 20, write 30, read 30 -> data order preserved across pointer wrap, empty=1 at end.
REQ-035 Full with simultaneous wr_en/rd_en (data 0xAA) -> level stays 32, head read out, 0xAA last out.
REQ-036 ier_thre=1, write 0x55, read it -> iir 0001->0010 on empty edge; iir_rd -> 0001; repeat, clear by write 0x11 -> 0001.
REQ-037 Level 10, tx_clr pulse with wr_en=1 -> level=0, empty=1, write ignored; reset mid-stream -> REQ-029 values immediately.
REQ-038 With UART_TX_FIFO_OVF_EN: write when full -> ovf=1, holds until iir_rd; without macro ovf stays 0.
